// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and stall signals around the IF/MEM memory arbiter.
// Latency: none, wires only.
// Backpressure: requesters hold req until their ack; stall_* freeze the pipeline meanwhile.
interface mem_port_arbiter_if #(
  parameter int W  = 16,
  parameter int AW = 16
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          if_ack;
  logic [W-1:0]  if_rdata;
  logic          mem_req;
  logic          mem_wr;
  logic [AW-1:0] mem_addr_in;
  logic [W-1:0]  mem_wdata_in;
  logic          mem_ack;
  logic [W-1:0]  mem_rdata_out;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_wdata;
  logic [W-1:0]  ram_rdata;
  logic          stall_fetch;
  logic          stall_mem;
  logic          busy;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, if_flush, mem_req, mem_wr, mem_addr_in, mem_wdata_in, ram_rdata,
    output if_ack, if_rdata, mem_ack, mem_rdata_out, ram_en, ram_we, ram_addr, ram_wdata,
           stall_fetch, stall_mem, busy
  );

  // Pipeline and memory side.
  modport master (
    output if_req, if_addr, if_flush, mem_req, mem_wr, mem_addr_in, mem_wdata_in, ram_rdata,
    input  if_ack, if_rdata, mem_ack, mem_rdata_out, ram_en, ram_we, ram_addr, ram_wdata,
           stall_fetch, stall_mem, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory between the fetch (IF) and memory-stage (MEM) ports.
// Latency: grant edge, then LAT ACCESS cycles, then one DONE cycle carrying the ack (LAT+2 per access).
// Backpressure: losing/waiting requester is stalled; MEM wins ties until MAX_STREAK, then IF goes.
module mem_port_arbiter #(
  parameter int W          = 16,
  parameter int AW         = 16,
  parameter int LAT        = 2,
  parameter int MAX_STREAK = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus
);
  localparam int CW = 3;
  localparam int SW = $clog2(MAX_STREAK + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} owner_t;

  state_t        state, state_n;
  owner_t        owner, owner_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SW-1:0] streak, streak_n;
  logic [AW-1:0] lat_addr, addr_n;
  logic          lat_wr, wr_n;
  logic [W-1:0]  lat_wdata, wdata_n;
  logic          killed, killed_n;

  logic cand_if, cand_mem, grant_if;
  logic in_access, in_done, first_access;

  // A flush in the same cycle keeps the fetch out of arbitration.
  assign cand_if  = bus.if_req & ~bus.if_flush;
  assign cand_mem = bus.mem_req;
  assign grant_if = cand_if & (~cand_mem | (streak == SW'(MAX_STREAK)));

  // State and latched-request registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_NONE;
      cnt       <= '0;
      streak    <= '0;
      lat_addr  <= '0;
      lat_wr    <= 1'b0;
      lat_wdata <= '0;
      killed    <= 1'b0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      cnt       <= cnt_n;
      streak    <= streak_n;
      lat_addr  <= addr_n;
      lat_wr    <= wr_n;
      lat_wdata <= wdata_n;
      killed    <= killed_n;
    end
  end

  // Arbitration, access countdown and fetch-kill tracking.
  always_comb begin
    state_n  = state;
    owner_n  = owner;
    cnt_n    = cnt;
    streak_n = streak;
    addr_n   = lat_addr;
    wr_n     = lat_wr;
    wdata_n  = lat_wdata;
    killed_n = killed;
    case (state)
      IDLE: begin
        if (cand_if | cand_mem) begin
          state_n  = ACCESS;
          cnt_n    = CW'(LAT - 1);
          killed_n = 1'b0;
          if (grant_if) begin
            owner_n  = OWN_IF;
            addr_n   = bus.if_addr;
            wr_n     = 1'b0;
            wdata_n  = '0;
            streak_n = '0;
          end else begin
            owner_n  = OWN_MEM;
            addr_n   = bus.mem_addr_in;
            wr_n     = bus.mem_wr;
            wdata_n  = bus.mem_wdata_in;
            // Only count MEM wins that actually made a fetch wait.
            if (cand_if)
              streak_n = (streak == SW'(MAX_STREAK)) ? streak : streak + SW'(1);
            else
              streak_n = '0;
          end
        end
      end
      ACCESS: begin
        if ((owner == OWN_IF) && bus.if_flush) killed_n = 1'b1;
        if (cnt == '0) state_n = DONE;
        else           cnt_n   = cnt - CW'(1);
      end
      DONE: begin
        state_n  = IDLE;
        owner_n  = OWN_NONE;
        killed_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  assign in_access    = (state == ACCESS);
  assign in_done      = (state == DONE);
  assign first_access = in_access && (cnt == CW'(LAT - 1));

  assign bus.ram_en    = first_access;
  assign bus.ram_we    = in_access & lat_wr;
  assign bus.ram_addr  = in_access ? lat_addr : '0;
  assign bus.ram_wdata = in_access ? lat_wdata : '0;

  // A flush landing in DONE also suppresses the fetch ack.
  assign bus.if_ack        = in_done & (owner == OWN_IF) & ~killed & ~bus.if_flush;
  assign bus.if_rdata      = bus.if_ack ? bus.ram_rdata : '0;
  assign bus.mem_ack       = in_done & (owner == OWN_MEM);
  assign bus.mem_rdata_out = (bus.mem_ack & ~lat_wr) ? bus.ram_rdata : '0;

  assign bus.stall_fetch = bus.if_req & ~bus.if_ack & ~bus.if_flush;
  assign bus.stall_mem   = bus.mem_req & ~bus.mem_ack;
  assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
// Latency: n/a.
// Backpressure: requesters hold req until ack; fetch may be flushed.
module tb_mem_port_arbiter;
  localparam int LAT  = 2;
  localparam int MAXS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.W(16), .AW(16)) bus ();

  mem_port_arbiter #(.W(16), .AW(16), .LAT(LAT), .MAX_STREAK(MAXS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] init_val(input logic [15:0] a);
    case (a)
      16'h0010: init_val = 16'hA5A5;
      16'h0200: init_val = 16'h1234;
      default:  init_val = (a * 16'h0101) ^ 16'h3C3C;
    endcase
  endfunction

  // Memory behind the arbiter: writes on ram_en&ram_we, reads appear LAT cycles after ram_en.
  logic [15:0] ram_map [logic [15:0]];
  logic [15:0] pipe0 = 16'hDEAD, pipe1 = 16'hDEAD;
  assign bus.ram_rdata = pipe1;
  initial begin
    logic c_en, c_we;
    logic [15:0] c_addr, c_wdata;
    forever begin
      @(negedge clk);
      c_en = bus.ram_en; c_we = bus.ram_we; c_addr = bus.ram_addr; c_wdata = bus.ram_wdata;
      @(posedge clk);
      pipe1 = pipe0;
      if (c_en && !c_we) pipe0 = ram_map.exists(c_addr) ? ram_map[c_addr] : init_val(c_addr);
      else               pipe0 = 16'hDEAD;
      if (c_en && c_we) ram_map[c_addr] = c_wdata;
    end
  end

  // Transaction-level model: one access at a time, occupying cycles [start, start+LAT] with ack at the end.
  logic [15:0] mdl_mem [logic [15:0]];
  int          cyc = 0;
  bit          m_act = 0, m_mem = 0, m_wr = 0, m_kill = 0;
  int          m_start = 0, m_done = 0, m_streak = 0;
  logic [15:0] m_addr = '0, m_wdata = '0, m_rd = '0;
  initial begin
    bit cif, cmem, take_mem;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_act = 0; m_kill = 0; m_streak = 0;
      end else if (m_act) begin
        if (!m_mem && bus.if_flush) m_kill = 1;
        if (cyc == m_done) begin m_act = 0; m_kill = 0; end
      end else begin
        cif  = bus.if_req && !bus.if_flush;
        cmem = bus.mem_req;
        if (cif || cmem) begin
          take_mem = cmem && !(cif && m_streak == MAXS);
          if (take_mem && cif) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
          else                 m_streak = 0;
          m_act = 1; m_kill = 0; m_mem = take_mem;
          m_start = cyc + 1; m_done = cyc + 1 + LAT;
          m_addr  = take_mem ? bus.mem_addr_in : bus.if_addr;
          m_wr    = take_mem && bus.mem_wr;
          m_wdata = take_mem ? bus.mem_wdata_in : 16'h0;
          m_rd    = mdl_mem.exists(m_addr) ? mdl_mem[m_addr] : init_val(m_addr);
          if (m_wr) mdl_mem[m_addr] = m_wdata;
        end
      end
      cyc++;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    bit act, in_acc, is_done, e_ifa, e_mema;
    forever begin
      @(negedge clk);
      act     = m_act && !rst;
      in_acc  = act && cyc >= m_start && cyc < m_done;
      is_done = act && cyc == m_done;
      e_ifa   = is_done && !m_mem && !m_kill && !bus.if_flush;
      e_mema  = is_done && m_mem;
      chk("ram_en",   bus.ram_en,   act && cyc == m_start);
      chk("ram_we",   bus.ram_we,   in_acc && m_wr);
      chk("ram_addr", bus.ram_addr, in_acc ? m_addr : 16'h0);
      chk("ram_wdata", bus.ram_wdata, in_acc ? m_wdata : 16'h0);
      chk("if_ack",   bus.if_ack,   e_ifa);
      chk("if_rdata", bus.if_rdata, e_ifa ? m_rd : 16'h0);
      chk("mem_ack",  bus.mem_ack,  e_mema);
      chk("mem_rdata", bus.mem_rdata_out, (e_mema && !m_wr) ? m_rd : 16'h0);
      chk("busy",     bus.busy,     act);
      chk("stall_fetch", bus.stall_fetch, bus.if_req && !e_ifa && !bus.if_flush);
      chk("stall_mem", bus.stall_mem, bus.mem_req && !e_mema);
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Waits for the chosen ack; n is the cycle index (0 = current) where it appeared.
  task automatic wait_ack(input bit want_mem, input bit chk_stall, input int bound,
                          output int n, output logic [15:0] d, output bit stall_ok);
    bit done;
    n = 0; d = '0; stall_ok = 1; done = 0;
    while (!done) begin
      @(negedge clk);
      if (chk_stall && !bus.if_ack && !bus.stall_fetch) stall_ok = 0;
      if (want_mem ? bus.mem_ack : bus.if_ack) begin
        d = want_mem ? bus.mem_rdata_out : bus.if_rdata;
        done = 1;
      end else begin
        n++;
        if (n > bound) done = 1;
      end
    end
  endtask

  initial begin
    int n, got, ncy;
    logic [15:0] d;
    bit sok, a_if, a_mem;
    int exp_ord [8] = '{1, 1, 1, 0, 1, 1, 1, 0};

    bus.if_req = 0; bus.if_addr = '0; bus.if_flush = 0;
    bus.mem_req = 0; bus.mem_wr = 0; bus.mem_addr_in = '0; bus.mem_wdata_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_en", bus.ram_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_acks", {bus.if_ack, bus.mem_ack}, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    #1 rst = 0;

    // Single fetch: ram_en in cycle 1, ack with data in cycle 3.
    next_cycle();
    bus.if_req = 1; bus.if_addr = 16'h0010;
    @(negedge clk);
    chk("t1_stall_c0", bus.stall_fetch, 1);
    chk("t1_ram_en_c0", bus.ram_en, 0);
    next_cycle(); @(negedge clk);
    chk("t1_ram_en_c1", bus.ram_en, 1);
    chk("t1_ram_addr_c1", bus.ram_addr, 16'h0010);
    chk("t1_stall_c1", bus.stall_fetch, 1);
    next_cycle(); @(negedge clk);
    chk("t1_ram_en_c2", bus.ram_en, 0);
    chk("t1_stall_c2", bus.stall_fetch, 1);
    next_cycle(); @(negedge clk);
    chk("t1_if_ack_c3", bus.if_ack, 1);
    chk("t1_if_rdata_c3", bus.if_rdata, 16'hA5A5);
    chk("t1_stall_c3", bus.stall_fetch, 0);
    next_cycle();
    bus.if_req = 0;

    // Simultaneous requests: MEM first, then IF; fetch stalled throughout.
    next_cycle();
    bus.if_req = 1; bus.if_addr = 16'h0010;
    bus.mem_req = 1; bus.mem_wr = 0; bus.mem_addr_in = 16'h0200;
    wait_ack(1, 1, 20, n, d, sok);
    chk("t2_mem_ack_cycle", n, 3);
    chk("t2_mem_rdata", d, 16'h1234);
    chk("t2_stall_during_mem", sok, 1);
    next_cycle();
    bus.mem_req = 0;
    wait_ack(0, 1, 20, n, d, sok);
    chk("t2_if_ack_cycle", n, 3);
    chk("t2_if_rdata", d, 16'hA5A5);
    chk("t2_stall_until_ack", sok, 1);
    next_cycle();
    bus.if_req = 0;

    // Both held: three MEM grants, one IF grant, repeating.
    next_cycle();
    bus.if_req = 1; bus.if_addr = 16'h0010;
    bus.mem_req = 1; bus.mem_wr = 0; bus.mem_addr_in = 16'h0200;
    for (int k = 0; k < 8; k++) begin
      got = 2; ncy = 0;
      while (got == 2 && ncy < 20) begin
        @(negedge clk);
        if (bus.mem_ack) got = 1;
        else if (bus.if_ack) got = 0;
        ncy++;
      end
      chk("t3_grant_order", got, exp_ord[k]);
    end
    next_cycle();
    bus.if_req = 0; bus.mem_req = 0;

    // Write: one ram_en/ram_we cycle, ack in DONE with zero read data.
    next_cycle();
    bus.mem_req = 1; bus.mem_wr = 1; bus.mem_addr_in = 16'h0033; bus.mem_wdata_in = 16'hBEEF;
    @(negedge clk);
    next_cycle(); @(negedge clk);
    chk("t4_en_we", {bus.ram_en, bus.ram_we}, 2'b11);
    chk("t4_addr", bus.ram_addr, 16'h0033);
    chk("t4_wdata", bus.ram_wdata, 16'hBEEF);
    next_cycle(); @(negedge clk);
    chk("t4_en_c2", bus.ram_en, 0);
    next_cycle(); @(negedge clk);
    chk("t4_mem_ack", bus.mem_ack, 1);
    chk("t4_mem_rdata", bus.mem_rdata_out, 0);
    next_cycle();
    bus.mem_req = 0; bus.mem_wr = 0;

    // Flushed fetch: no ack, idle again at LAT+2, next fetch normal.
    next_cycle();
    bus.if_req = 1; bus.if_addr = 16'h0040;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t5_no_if_ack", bus.if_ack, 0);
      next_cycle();
      bus.if_flush = (c == 0);
      if (c >= 1) bus.if_req = 0;
    end
    @(negedge clk);
    chk("t5_idle_after", bus.busy, 0);
    next_cycle();
    bus.if_req = 1; bus.if_addr = 16'h0010;
    wait_ack(0, 0, 20, n, d, sok);
    chk("t5_refetch_cycle", n, 3);
    chk("t5_refetch_data", d, 16'hA5A5);
    next_cycle();
    bus.if_req = 0;

    // Reset during ACCESS clears outputs at once and leaves no stale ack.
    next_cycle();
    bus.mem_req = 1; bus.mem_wr = 0; bus.mem_addr_in = 16'h0200;
    @(negedge clk);
    next_cycle(); @(negedge clk);
    chk("t6_in_access", bus.ram_en, 1);
    #2 rst = 1;
    #1;
    chk("t6_async_en", bus.ram_en, 0);
    chk("t6_async_addr", bus.ram_addr, 0);
    chk("t6_async_busy", bus.busy, 0);
    bus.mem_req = 0;
    @(negedge clk); @(negedge clk);
    #1 rst = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t6_no_stale", {bus.mem_ack, bus.if_ack, bus.busy}, 0);
    end

    // Random traffic; the compare process checks every cycle.
    repeat (3000) begin
      @(negedge clk);
      a_if = bus.if_ack; a_mem = bus.mem_ack;
      next_cycle();
      if (bus.mem_req && a_mem) bus.mem_req = 0;
      else if (!bus.mem_req && $urandom_range(0, 2) == 0) begin
        bus.mem_req = 1;
        bus.mem_wr = 1'($urandom_range(0, 1));
        bus.mem_addr_in = 16'($urandom_range(0, 15));
        bus.mem_wdata_in = 16'($urandom);
      end
      if (bus.if_flush) begin
        bus.if_flush = 0; bus.if_req = 0;
      end else if (bus.if_req && a_if) bus.if_req = 0;
      else if (!bus.if_req && $urandom_range(0, 2) == 0) begin
        bus.if_req = 1;
        bus.if_addr = 16'($urandom_range(0, 15));
      end else if (bus.if_req && $urandom_range(0, 15) == 0) bus.if_flush = 1;
    end
    next_cycle();
    bus.if_req = 0; bus.mem_req = 0; bus.if_flush = 0;
    repeat (8) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
